// File: rtl/bank_inrd_ctrl.sv
// Per-bank input-read-enable sequencer: changes one bank's INRDENI at a time,
// round-robin, and holds off further changes until that bank's buffers settle.
module bank_inrd_ctrl #(
   parameter int NUM_BANKS  = 4,
   parameter int SETTLE_CYC = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_BANKS-1:0] req_en,
   output logic [NUM_BANKS-1:0] inrden,
   output logic [NUM_BANKS-1:0] bank_ready,
   output logic                 busy,
   output logic [2:0]           cur_bank
);

   localparam int IW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [IW-1:0]        rr_ptr;
   logic [IW-1:0]        cur_idx;
   logic [IW-1:0]        grant_idx;
   logic [IW:0]          scan_idx;
   logic [7:0]           counter;
   logic [NUM_BANKS-1:0] pending;
   logic                 found;
   logic                 grant;
   logic                 done;

   assign pending  = req_en ^ inrden;
   assign busy     = (state == SETTLE);
   assign cur_bank = 3'(cur_idx);

   // First pending bank at or after rr_ptr, wrapping; rr_ptr < NUM_BANKS so one subtract suffices.
   always_comb begin
      found     = 1'b0;
      grant_idx = rr_ptr;
      scan_idx  = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         scan_idx = {1'b0, rr_ptr} + (IW+1)'(i);
         if (scan_idx >= (IW+1)'(NUM_BANKS)) begin
            scan_idx = scan_idx - (IW+1)'(NUM_BANKS);
         end
         if (!found && pending[scan_idx[IW-1:0]]) begin
            found     = 1'b1;
            grant_idx = scan_idx[IW-1:0];
         end
      end
   end

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               grant      = 1'b1;
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (counter == 8'd0) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A reset mid-SETTLE simply drops everything, so the aborted bank never reports ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inrden     <= '0;
         bank_ready <= '0;
         cur_idx    <= '0;
         rr_ptr     <= '0;
         counter    <= 8'd0;
      end else if (grant) begin
         inrden[grant_idx]     <= req_en[grant_idx];
         bank_ready[grant_idx] <= 1'b0;
         cur_idx               <= grant_idx;
         rr_ptr                <= (grant_idx == IW'(NUM_BANKS-1)) ? '0 : grant_idx + IW'(1);
         counter               <= 8'(SETTLE_CYC-1);
      end else if (done) begin
         bank_ready[cur_idx] <= inrden[cur_idx];
      end else if (busy) begin
         counter <= counter - 8'd1;
      end
   end

endmodule

// File: doc/bank_inrd_ctrl.md
BANK_INRD_CTRL -- requirements
Module: bank_inrd_ctrl

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of I/O banks whose input-read-enable is controlled (range 2..8).
REQ-002 SHALL have parameter SETTLE_CYC, default 16, clock cycles a bank's input buffers need after an enable change (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_en  input  NUM_BANKS  per-bank level request; 1 = input read wanted, 0 = bank input buffers off.
REQ-006 SHALL have port inrden  output  NUM_BANKS  per-bank drive to the bank's BCINRD INRDENI pin.
REQ-007 SHALL have port bank_ready  output  NUM_BANKS  per-bank flag: enabled and settled.
REQ-008 SHALL have port busy  output  1  high while a bank transition is settling.
REQ-009 SHALL have port cur_bank  output  3  index of the bank granted most recently, or currently settling.

Function
REQ-010 SHALL implement a two-state FSM, IDLE and SETTLE; busy = (state == SETTLE), combinational from the state register.
REQ-011 SHALL define a bank b as pending when req_en[b] != inrden[b].
REQ-012 In IDLE with at least one pending bank, SHALL grant exactly one bank per edge, chosen round-robin: the first pending index at or after rr_ptr, wrapping modulo NUM_BANKS.
REQ-013 On a grant edge to bank b: inrden[b] <= req_en[b]; bank_ready[b] <= 0; cur_bank <= b; rr_ptr <= (b+1) mod NUM_BANKS; counter <= SETTLE_CYC-1; state <= SETTLE.
REQ-014 In SETTLE, the counter SHALL decrement by 1 each edge while nonzero; on the edge where it is 0: bank_ready[cur_bank] <= inrden[cur_bank]; state <= IDLE.
REQ-015 bank_ready[b] SHALL therefore rise exactly SETTLE_CYC cycles after inrden[b] rises, and SHALL fall on the same edge on which inrden[b] falls.
REQ-016 SHALL never change more than one inrden bit on any edge, and SHALL never grant while in SETTLE.
REQ-017 SHALL ignore req_en changes during SETTLE, including a change on the settling bank; they are re-evaluated as pending once IDLE is reached.
REQ-018 A bank whose req_en toggles and returns before it is granted SHALL not be granted (it is not pending).
REQ-019 After every SETTLE, SHALL spend at least one cycle in IDLE before the next grant.
REQ-020 The counter SHALL be 8 bits and SHALL never underflow; no wrap-around from 0.
REQ-021 With no pending bank, IDLE SHALL hold all outputs and rr_ptr unchanged.

Reset
REQ-022 On rst_n low, asynchronously: inrden = 0, bank_ready = 0, busy = 0, cur_bank = 0, rr_ptr = 0, counter = 0, state = IDLE.
REQ-023 Reset asserted mid-SETTLE SHALL abort the transition; no bank_ready update occurs for the aborted bank.
REQ-024 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge at which rst_n is high.

Verification (NUM_BANKS=4, SETTLE_CYC=3)
REQ-025 Single enable: req_en=0001 after reset. Required: inrden=0001 on the next edge, busy high 3 cycles, bank_ready=0001 three cycles after inrden rose, busy low.
REQ-026 Simultaneous requests: req_en 0000->1111 in one cycle. Required: grants in order 0,1,2,3; each grant is 3 SETTLE cycles plus 1 IDLE cycle apart; never more than one inrden bit changing per edge; final bank_ready=1111.
REQ-027 Round-robin fairness: bank 1 just granted, then banks 0 and 3 pending. Required: bank 3 granted before bank 0.
REQ-028 Disable: all banks ready, then req_en[2] 1->0. Required: on the grant edge inrden[2]=0 and bank_ready[2]=0 simultaneously; after settle, bank_ready[2] stays 0.
REQ-029 Mid-settle change: during bank 0 SETTLE, req_en[0] drops and req_en[1] rises. Required: bank 0 completes with ready=1; then bank 0 is disabled or bank 1 enabled per round-robin (bank 1 first, since rr_ptr=1).
REQ-030 Reset abort: rst_n pulsed low during the second SETTLE cycle. Required: all outputs immediately 0; the sequence restarts from bank 0 after release.
